// File: rtl/sy_pkg.sv
// Shared definitions for the SY pipeline flush controller.
// Optional WFI sleep support is enabled by defining SY_PPL_CTRL_WFI_EN.
package sy_pkg;

`ifdef SY_PPL_CTRL_WFI_EN
    typedef enum logic [3:0] {
        FSM_RESET     = 4'd0,
        FSM_INIT_PC   = 4'd1,
        FSM_PROC      = 4'd2,
        FSM_RUN       = 4'd3,
        FSM_DRAIN     = 4'd4,
        FSM_MAINT_DC  = 4'd5,
        FSM_MAINT_IC  = 4'd6,
        FSM_MAINT_TLB = 4'd7,
        FSM_SLEEP     = 4'd8
    } sy_ppl_ctrl_fsm_e;
`else
    typedef enum logic [3:0] {
        FSM_RESET     = 4'd0,
        FSM_INIT_PC   = 4'd1,
        FSM_PROC      = 4'd2,
        FSM_RUN       = 4'd3,
        FSM_DRAIN     = 4'd4,
        FSM_MAINT_DC  = 4'd5,
        FSM_MAINT_IC  = 4'd6,
        FSM_MAINT_TLB = 4'd7
    } sy_ppl_ctrl_fsm_e;
`endif

    // Bit positions inside the maint pending vector {tlb, ic, dc}
    localparam int unsigned MAINT_DC_BIT  = 0;
    localparam int unsigned MAINT_IC_BIT  = 1;
    localparam int unsigned MAINT_TLB_BIT = 2;

    // Default PC entered on a debug halt request
    localparam logic [63:0] SY_DBG_HALT_ADDR = 64'h800;

endpackage

// File: rtl/sy_ppl_evt_latch.sv
// Event capture for the flush controller: picks the redirect PC by
// priority, accumulates pending bits and produces the registered kill.
// The sleep pending bit exists only when SY_PPL_CTRL_WFI_EN is defined.
module sy_ppl_evt_latch
    import sy_pkg::*;
#(
    parameter int unsigned     NSTAGE        = 5,
    parameter int unsigned     AWTH          = 64,
    parameter logic [AWTH-1:0] DBG_HALT_ADDR = AWTH'(SY_DBG_HALT_ADDR)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AWTH-1:0]   boot_addr,
    input  logic              load_boot,
    input  logic              ex_valid,
    input  logic [AWTH-1:0]   trap_vec,
    input  logic              eret,
    input  logic [AWTH-1:0]   epc,
    input  logic              set_debug,
    input  logic              csr_flush,
    input  logic              fencei,
    input  logic              fence,
    input  logic              sfence,
    input  logic [AWTH-1:0]   wb_npc,
`ifdef SY_PPL_CTRL_WFI_EN
    input  logic              wfi,
    input  logic              debug_mode,
    input  logic              clr_sleep,
    output logic              sleep,
`endif
    input  logic              clr_hard,
    input  logic              clr_soft,
    input  logic [2:0]        clr_maint,
    output logic [AWTH-1:0]   pc,
    output logic              excp,
    output logic              xret,
    output logic              dbg,
    output logic              flush,
    output logic [2:0]        maint,
    output logic              evt_any,
    output logic [NSTAGE-1:0] kill
);

    logic            hi_evt;
    logic            lo_evt;
    logic            sleep_set;
    logic [2:0]      maint_set;
    logic [AWTH-1:0] evt_pc;
    logic [AWTH-1:0] pc_reg;
    logic            excp_reg;
    logic            xret_reg;
    logic            dbg_reg;
    logic            flush_reg;
    logic [2:0]      maint_reg;
    logic [NSTAGE-1:0] kill_reg;
`ifdef SY_PPL_CTRL_WFI_EN
    logic            sleep_reg;
`endif

    // Classify this cycle's events and select the redirect target by priority
    always_comb begin
`ifdef SY_PPL_CTRL_WFI_EN
        sleep_set = wfi && !debug_mode && !ex_valid;
`else
        sleep_set = 1'b0;
`endif
        hi_evt    = ex_valid || eret || set_debug;
        lo_evt    = fencei || fence || sfence || csr_flush || sleep_set;
        evt_any   = hi_evt || lo_evt;
        // Fence-type work is dropped when a trap/xret/debug retires alongside it
        maint_set = 3'b000;
        maint_set[MAINT_DC_BIT]  = (fencei || fence) && !hi_evt;
        maint_set[MAINT_IC_BIT]  = fencei && !hi_evt;
        maint_set[MAINT_TLB_BIT] = sfence && !hi_evt;
        if (ex_valid) begin
            evt_pc = trap_vec;
        end else if (eret) begin
            evt_pc = epc;
        end else if (set_debug) begin
            evt_pc = DBG_HALT_ADDR;
        end else begin
            evt_pc = wb_npc;
        end
    end

    // Pending bits: a soft clear still lets same-cycle events through, a hard clear wins over all
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_reg    <= '0;
            excp_reg  <= 1'b0;
            xret_reg  <= 1'b0;
            dbg_reg   <= 1'b0;
            flush_reg <= 1'b0;
            maint_reg <= 3'b000;
            kill_reg  <= '0;
`ifdef SY_PPL_CTRL_WFI_EN
            sleep_reg <= 1'b0;
`endif
        end else begin
            kill_reg <= {NSTAGE{evt_any}};
            // A late low-priority event must not overwrite an outstanding trap-class target
            if (hi_evt || (lo_evt && !((excp_reg || xret_reg || dbg_reg) && !clr_soft))) begin
                pc_reg <= evt_pc;
            end else if (load_boot) begin
                pc_reg <= boot_addr;
            end
            if (clr_hard) begin
                excp_reg  <= 1'b0;
                xret_reg  <= 1'b0;
                dbg_reg   <= 1'b0;
                flush_reg <= 1'b0;
                maint_reg <= 3'b000;
            end else begin
                excp_reg  <= (excp_reg && !clr_soft) || ex_valid;
                xret_reg  <= (xret_reg && !clr_soft) || eret;
                dbg_reg   <= (dbg_reg && !clr_soft) || set_debug;
                flush_reg <= (flush_reg && !clr_soft) || (lo_evt && !sleep_set && !hi_evt)
                             || (!hi_evt && (fencei || fence || sfence || csr_flush));
                maint_reg <= (maint_reg & ~(clr_maint | {3{clr_soft}})) | maint_set;
            end
`ifdef SY_PPL_CTRL_WFI_EN
            if (clr_hard) begin
                sleep_reg <= 1'b0;
            end else begin
                sleep_reg <= (sleep_reg && !clr_soft && !clr_sleep) || sleep_set;
            end
`endif
        end
    end

    assign pc    = pc_reg;
    assign excp  = excp_reg;
    assign xret  = xret_reg;
    assign dbg   = dbg_reg;
    assign flush = flush_reg;
    assign maint = maint_reg;
    assign kill  = kill_reg;
`ifdef SY_PPL_CTRL_WFI_EN
    assign sleep = sleep_reg;
`endif

endmodule

// File: rtl/sy_ppl_flush_ctrl.sv
// Pipeline flush / redirect / maintenance sequencer for the SY core.
// Drains the pipeline, issues kills and fetch redirects, runs cache and
// TLB maintenance handshakes and bounds draining with a watchdog.
// WFI sleep support is compiled in when SY_PPL_CTRL_WFI_EN is defined.
module sy_ppl_flush_ctrl
    import sy_pkg::*;
#(
    parameter int unsigned     NSTAGE        = 5,
    parameter int unsigned     NFU           = 2,
    parameter int unsigned     AWTH          = 64,
    parameter int unsigned     DRAIN_TO      = 256,
    parameter logic [AWTH-1:0] DBG_HALT_ADDR = AWTH'(SY_DBG_HALT_ADDR)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [AWTH-1:0]   boot_addr_i,
    input  logic              ctrl_reset_i,
    input  logic              ctrl_halt_i,
    input  logic [NSTAGE-1:0] stage_act_i,
    input  logic [NFU-1:0]    fu_act_i,
    output logic [NSTAGE-1:0] kill_o,
    output logic              fet_act_o,
    output logic              fet_set_en_o,
    output logic [AWTH-1:0]   fet_set_npc_o,
    output logic              flush_bp_o,
    input  logic              csr_ex_valid_i,
    input  logic [AWTH-1:0]   csr_trap_vec_i,
    input  logic              csr_eret_i,
    input  logic [AWTH-1:0]   csr_epc_i,
    input  logic              csr_set_debug_i,
    input  logic              csr_flush_i,
    input  logic              alu_fencei_i,
    input  logic              alu_fence_i,
    input  logic              alu_sfence_i,
    input  logic [AWTH-1:0]   alu_wb_npc_i,
    output logic              icache_flush_o,
    output logic              dcache_flush_o,
    input  logic              dcache_flush_ack_i,
    output logic              tlb_flush_o,
    input  logic              tlb_flush_ack_i,
`ifdef SY_PPL_CTRL_WFI_EN
    input  logic              alu_wfi_i,
    input  logic              csr_wfi_wakeup_i,
    input  logic              csr_debug_mode_i,
`endif
    output logic              stat_sleep_o,
    output logic              stat_drain_err_o
);

    localparam int unsigned CW = (DRAIN_TO > 2) ? $clog2(DRAIN_TO) : 1;

    sy_ppl_ctrl_fsm_e state_reg;
    logic [CW-1:0]    wd_cnt_reg;
    logic             set_en_reg;
    logic [AWTH-1:0]  set_npc_reg;
    logic             flush_bp_reg;
    logic             icache_reg;
    logic             dcache_reg;
    logic             tlb_reg;
    logic             drain_err_reg;

    logic [AWTH-1:0]  pc;
    logic             excp;
    logic             xret;
    logic             dbg;
    logic             flush;
    logic [2:0]       maint;
    logic             evt_any;
    logic             pend_any;
    logic             only_sleep;
    logic             idle;
    logic             clr_soft;
    logic [2:0]       clr_maint;
    logic             load_boot;
    logic             sleep;
    logic             clr_sleep;

    sy_ppl_evt_latch #(
        .NSTAGE        (NSTAGE),
        .AWTH          (AWTH),
        .DBG_HALT_ADDR (DBG_HALT_ADDR)
    ) u_evt_latch (
        .clk        (clk_i),
        .rst_n      (rst_i),
        .boot_addr  (boot_addr_i),
        .load_boot  (load_boot),
        .ex_valid   (csr_ex_valid_i),
        .trap_vec   (csr_trap_vec_i),
        .eret       (csr_eret_i),
        .epc        (csr_epc_i),
        .set_debug  (csr_set_debug_i),
        .csr_flush  (csr_flush_i),
        .fencei     (alu_fencei_i),
        .fence      (alu_fence_i),
        .sfence     (alu_sfence_i),
        .wb_npc     (alu_wb_npc_i),
`ifdef SY_PPL_CTRL_WFI_EN
        .wfi        (alu_wfi_i),
        .debug_mode (csr_debug_mode_i),
        .clr_sleep  (clr_sleep),
        .sleep      (sleep),
`endif
        .clr_hard   (ctrl_reset_i),
        .clr_soft   (clr_soft),
        .clr_maint  (clr_maint),
        .pc         (pc),
        .excp       (excp),
        .xret       (xret),
        .dbg        (dbg),
        .flush      (flush),
        .maint      (maint),
        .evt_any    (evt_any),
        .kill       (kill_o)
    );

`ifndef SY_PPL_CTRL_WFI_EN
    assign sleep = 1'b0;
`endif

    // Decode pending-bit clears and PC boot load from the current state
    always_comb begin
        idle       = (stage_act_i == '0) && (fu_act_i == '0);
        pend_any   = excp || xret || dbg || flush || (maint != 3'b000) || sleep;
        only_sleep = sleep && !excp && !xret && !dbg && !flush;
        load_boot  = (state_reg == FSM_INIT_PC);
        clr_soft   = (state_reg == FSM_PROC) && !ctrl_halt_i && (maint == 3'b000) && !only_sleep;
        clr_sleep  = (state_reg == FSM_PROC) && !ctrl_halt_i && (maint == 3'b000) && only_sleep;
        clr_maint  = 3'b000;
        clr_maint[MAINT_DC_BIT]  = (state_reg == FSM_MAINT_DC) && dcache_flush_ack_i;
        clr_maint[MAINT_IC_BIT]  = (state_reg == FSM_MAINT_IC);
        clr_maint[MAINT_TLB_BIT] = (state_reg == FSM_MAINT_TLB) && tlb_flush_ack_i;
    end

    // Controller FSM with registered redirect, flush and maintenance outputs
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg     <= FSM_RESET;
            wd_cnt_reg    <= '0;
            set_en_reg    <= 1'b0;
            set_npc_reg   <= '0;
            flush_bp_reg  <= 1'b0;
            icache_reg    <= 1'b0;
            dcache_reg    <= 1'b0;
            tlb_reg       <= 1'b0;
            drain_err_reg <= 1'b0;
        end else begin
            set_en_reg   <= 1'b0;
            flush_bp_reg <= 1'b0;
            icache_reg   <= 1'b0;
            wd_cnt_reg   <= '0;
            if (ctrl_reset_i) begin
                state_reg  <= FSM_RESET;
                dcache_reg <= 1'b0;
                tlb_reg    <= 1'b0;
            end else begin
                case (state_reg)
                    FSM_RESET: begin
                        if (idle) begin
                            state_reg    <= FSM_INIT_PC;
                            flush_bp_reg <= 1'b1;
                        end
                    end
                    FSM_INIT_PC: begin
                        state_reg <= FSM_PROC;
                    end
                    FSM_PROC: begin
                        if (!ctrl_halt_i) begin
                            if (maint != 3'b000) begin
                                set_en_reg  <= 1'b1;
                                set_npc_reg <= pc;
                                if (maint[MAINT_DC_BIT]) begin
                                    state_reg  <= FSM_MAINT_DC;
                                    dcache_reg <= 1'b1;
                                end else if (maint[MAINT_IC_BIT]) begin
                                    state_reg  <= FSM_MAINT_IC;
                                    icache_reg <= 1'b1;
                                end else begin
                                    state_reg <= FSM_MAINT_TLB;
                                    tlb_reg   <= 1'b1;
                                end
`ifdef SY_PPL_CTRL_WFI_EN
                            end else if (only_sleep) begin
                                state_reg <= FSM_SLEEP;
`endif
                            end else begin
                                set_en_reg   <= 1'b1;
                                set_npc_reg  <= pc;
                                state_reg    <= FSM_RUN;
                                flush_bp_reg <= excp || xret;
                            end
                        end
                    end
                    FSM_RUN: begin
                        if (ctrl_halt_i || evt_any || pend_any) begin
                            state_reg <= FSM_DRAIN;
                        end
                    end
                    FSM_DRAIN: begin
                        // A clean drain wins; only a stuck pipeline trips the watchdog
                        if (idle) begin
                            state_reg <= FSM_PROC;
                        end else if (wd_cnt_reg == CW'(DRAIN_TO - 1)) begin
                            state_reg     <= FSM_PROC;
                            drain_err_reg <= 1'b1;
                        end else begin
                            wd_cnt_reg <= wd_cnt_reg + 1'b1;
                        end
                    end
                    FSM_MAINT_DC: begin
                        if (dcache_flush_ack_i) begin
                            dcache_reg <= 1'b0;
                            state_reg  <= FSM_PROC;
                        end
                    end
                    FSM_MAINT_IC: begin
                        state_reg <= FSM_PROC;
                    end
                    FSM_MAINT_TLB: begin
                        if (tlb_flush_ack_i) begin
                            tlb_reg   <= 1'b0;
                            state_reg <= FSM_PROC;
                        end
                    end
`ifdef SY_PPL_CTRL_WFI_EN
                    FSM_SLEEP: begin
                        if (csr_wfi_wakeup_i || csr_ex_valid_i) begin
                            state_reg <= FSM_PROC;
                        end
                    end
`endif
                    default: begin
                        state_reg <= FSM_RESET;
                    end
                endcase
            end
        end
    end

    assign fet_act_o        = (state_reg == FSM_RUN);
    assign fet_set_en_o     = set_en_reg;
    assign fet_set_npc_o    = set_npc_reg;
    assign flush_bp_o       = flush_bp_reg;
    assign icache_flush_o   = icache_reg;
    assign dcache_flush_o   = dcache_reg;
    assign tlb_flush_o      = tlb_reg;
    assign stat_drain_err_o = drain_err_reg;
`ifdef SY_PPL_CTRL_WFI_EN
    assign stat_sleep_o     = (state_reg == FSM_SLEEP);
`else
    assign stat_sleep_o     = 1'b0;
`endif

endmodule

// File: tb/tb_sy_ppl_flush_ctrl.sv
// Directed self-checking bench for sy_ppl_flush_ctrl (DRAIN_TO = 8).
module tb_sy_ppl_flush_ctrl;

    localparam int NSTAGE = 5;
    localparam int NFU    = 2;
    localparam int AWTH   = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [AWTH-1:0]   boot_addr = '0;
    logic              ctrl_reset = 1'b0;
    logic              ctrl_halt = 1'b0;
    logic [NSTAGE-1:0] stage_act = '0;
    logic [NFU-1:0]    fu_act = '0;
    logic [NSTAGE-1:0] kill;
    logic              fet_act;
    logic              fet_set_en;
    logic [AWTH-1:0]   fet_set_npc;
    logic              flush_bp;
    logic              ex_valid = 1'b0;
    logic [AWTH-1:0]   trap_vec = '0;
    logic              eret = 1'b0;
    logic [AWTH-1:0]   epc = '0;
    logic              set_debug = 1'b0;
    logic              csr_flush = 1'b0;
    logic              fencei = 1'b0;
    logic              fence = 1'b0;
    logic              sfence = 1'b0;
    logic [AWTH-1:0]   wb_npc = '0;
    logic              icache_flush;
    logic              dcache_flush;
    logic              dcache_ack = 1'b0;
    logic              tlb_flush;
    logic              tlb_ack = 1'b0;
    logic              stat_sleep;
    logic              stat_drain_err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sy_ppl_flush_ctrl #(
        .NSTAGE   (NSTAGE),
        .NFU      (NFU),
        .AWTH     (AWTH),
        .DRAIN_TO (8)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .boot_addr_i        (boot_addr),
        .ctrl_reset_i       (ctrl_reset),
        .ctrl_halt_i        (ctrl_halt),
        .stage_act_i        (stage_act),
        .fu_act_i           (fu_act),
        .kill_o             (kill),
        .fet_act_o          (fet_act),
        .fet_set_en_o       (fet_set_en),
        .fet_set_npc_o      (fet_set_npc),
        .flush_bp_o         (flush_bp),
        .csr_ex_valid_i     (ex_valid),
        .csr_trap_vec_i     (trap_vec),
        .csr_eret_i         (eret),
        .csr_epc_i          (epc),
        .csr_set_debug_i    (set_debug),
        .csr_flush_i        (csr_flush),
        .alu_fencei_i       (fencei),
        .alu_fence_i        (fence),
        .alu_sfence_i       (sfence),
        .alu_wb_npc_i       (wb_npc),
        .icache_flush_o     (icache_flush),
        .dcache_flush_o     (dcache_flush),
        .dcache_flush_ack_i (dcache_ack),
        .tlb_flush_o        (tlb_flush),
        .tlb_flush_ack_i    (tlb_ack),
`ifdef SY_PPL_CTRL_WFI_EN
        .alu_wfi_i          (1'b0),
        .csr_wfi_wakeup_i   (1'b0),
        .csr_debug_mode_i   (1'b0),
`endif
        .stat_sleep_o       (stat_sleep),
        .stat_drain_err_o   (stat_drain_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        // ---- reset state
        boot_addr = 64'h8000_0000;
        repeat (3) tick();
        check("rst_kill", kill, 0);
        check("rst_fet_act", fet_act, 0);
        check("rst_set_en", fet_set_en, 0);
        check("rst_npc", fet_set_npc, 0);
        check("rst_flush_bp", flush_bp, 0);
        check("rst_dc", dcache_flush, 0);
        check("rst_tlb", tlb_flush, 0);
        check("rst_sleep", stat_sleep, 0);
        check("rst_err", stat_drain_err, 0);

        // ---- boot: RESET -> INIT_PC -> PROC -> RUN
        rst = 1'b1;
        tick();
        check("boot_bp_pulse", flush_bp, 1);
        check("boot_set_en0", fet_set_en, 0);
        tick();
        check("boot_bp_low", flush_bp, 0);
        check("boot_set_en1", fet_set_en, 0);
        tick();
        check("boot_set_en", fet_set_en, 1);
        check("boot_npc", fet_set_npc, 64'h8000_0000);
        check("boot_fet_act", fet_act, 1);
        check("boot_bp_none", flush_bp, 0);
        tick();
        check("boot_en_pulse", fet_set_en, 0);
        check("boot_run", fet_act, 1);

        // ---- stray ack outside MAINT does nothing
        dcache_ack = 1'b1;
        tick();
        dcache_ack = 1'b0;
        check("stray_ack_run", fet_act, 1);
        check("stray_ack_dc", dcache_flush, 0);

        // ---- trap in RUN with a busy stage
        ex_valid  = 1'b1;
        trap_vec  = 64'h100;
        stage_act = 5'b00001;
        tick();
        ex_valid = 1'b0;
        check("trap_kill", kill, 5'h1f);
        check("trap_drain", fet_act, 0);
        tick();
        check("trap_kill_end", kill, 0);
        check("trap_no_redir", fet_set_en, 0);
        stage_act = '0;
        tick();
        check("trap_proc", fet_set_en, 0);
        tick();
        check("trap_set_en", fet_set_en, 1);
        check("trap_npc", fet_set_npc, 64'h100);
        check("trap_bp", flush_bp, 1);
        check("trap_run", fet_act, 1);
        tick();
        check("trap_bp_end", flush_bp, 0);

        // ---- fence.i: D$ flush with delayed ack, I$ pulse, then redirect
        fencei = 1'b1;
        wb_npc = 64'h2004;
        tick();
        fencei = 1'b0;
        check("fi_kill", kill, 5'h1f);
        tick();
        check("fi_proc_dc", dcache_flush, 0);
        tick();
        check("fi_dc_enter_en", fet_set_en, 1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("fi_dc_hold%0d", i), dcache_flush, 1);
            check($sformatf("fi_ic_idle%0d", i), icache_flush, 0);
            if (i == 5) dcache_ack = 1'b1;
            tick();
        end
        dcache_ack = 1'b0;
        check("fi_dc_drop", dcache_flush, 0);
        check("fi_ic_wait", icache_flush, 0);
        tick();
        check("fi_ic_pulse", icache_flush, 1);
        tick();
        check("fi_ic_end", icache_flush, 0);
        check("fi_no_run", fet_act, 0);
        tick();
        check("fi_set_en", fet_set_en, 1);
        check("fi_npc", fet_set_npc, 64'h2004);
        check("fi_bp", flush_bp, 0);
        check("fi_run", fet_act, 1);
        tick();

        // ---- fence.i together with a trap: fence discarded
        fencei   = 1'b1;
        ex_valid = 1'b1;
        wb_npc   = 64'h3004;
        trap_vec = 64'h300;
        tick();
        fencei   = 1'b0;
        ex_valid = 1'b0;
        check("ft_kill", kill, 5'h1f);
        tick();
        check("ft_dc_proc", dcache_flush, 0);
        tick();
        check("ft_dc", dcache_flush, 0);
        check("ft_ic", icache_flush, 0);
        check("ft_set_en", fet_set_en, 1);
        check("ft_npc", fet_set_npc, 64'h300);
        check("ft_bp", flush_bp, 1);
        check("ft_run", fet_act, 1);
        tick();

        // ---- halt: RUN -> DRAIN -> PROC held, release -> RUN
        ctrl_halt = 1'b1;
        tick();
        check("halt_drain", fet_act, 0);
        tick();
        tick();
        check("halt_hold_en", fet_set_en, 0);
        check("halt_hold_act", fet_act, 0);
        ctrl_halt = 1'b0;
        tick();
        check("halt_rel_en", fet_set_en, 1);
        check("halt_rel_npc", fet_set_npc, 64'h300);
        check("halt_rel_bp", flush_bp, 0);
        tick();

        // ---- watchdog: stuck stage 2, DRAIN_TO = 8
        stage_act = 5'b00100;
        csr_flush = 1'b1;
        wb_npc    = 64'h4000;
        tick();
        csr_flush = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("wd_err_low%0d", i), stat_drain_err, 0);
            check($sformatf("wd_drain%0d", i), fet_act, 0);
            tick();
        end
        check("wd_err_set", stat_drain_err, 1);
        check("wd_proc_en", fet_set_en, 0);
        tick();
        check("wd_set_en", fet_set_en, 1);
        check("wd_npc", fet_set_npc, 64'h4000);
        check("wd_run", fet_act, 1);
        stage_act = '0;
        tick();
        check("wd_sticky", stat_drain_err, 1);

        // ---- sfence then soft reset while in MAINT_TLB
        sfence = 1'b1;
        wb_npc = 64'h5000;
        tick();
        sfence = 1'b0;
        tick();
        tick();
        check("tlb_req", tlb_flush, 1);
        tick();
        check("tlb_hold", tlb_flush, 1);
        ctrl_reset = 1'b1;
        tick();
        ctrl_reset = 1'b0;
        check("srst_tlb_drop", tlb_flush, 0);
        check("srst_fet_act", fet_act, 0);
        tlb_ack   = 1'b1;
        boot_addr = 64'h9000;
        tick();
        tlb_ack = 1'b0;
        check("srst_bp", flush_bp, 1);
        tick();
        tick();
        check("srst_set_en", fet_set_en, 1);
        check("srst_npc", fet_set_npc, 64'h9000);
        check("srst_run", fet_act, 1);
        check("srst_no_tlb", tlb_flush, 0);
        tick();
        check("srst_stay_run", fet_act, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
